ex_div_unit: RTL and testbench
==============================

Name: ex_div_unit

Overview:
Iterative 32-bit integer divider in the EX stage, serving DIV.W, DIV.WU, MOD.W and MOD.WU.
- Raises the EX stall request consumed by the pipeline controller while a division is in flight.
- Holds quotient and remainder stable until the EX instruction advances.
- Aborts on pipeline flush.

Parameters:
WIDTH, 32, operand/result width in bits.
CNT_W, 5, iteration counter width; must satisfy 2^CNT_W == WIDTH.

Ports:
clk  input  1  system clock; all state updates on rising edge.
resetn  input  1  reset; asynchronous, active-low.
div_en  input  1  EX holds a divide/modulo instruction; held high while EX is stalled.
div_signed  input  1  1 = signed (DIV.W/MOD.W), 0 = unsigned; sampled at start.
x  input  WIDTH  dividend; sampled at start.
y  input  WIDTH  divisor; sampled at start.
flush  input  1  pipeline flush from the pipeline controller.
ex_stall  input  1  stall bit for EX from the pipeline controller; 1 = EX does not advance this cycle.
stallreq_div  output  1  combinational stall request, ORed into the EX stall request.
div_valid  output  1  quotient/remainder valid (state DONE).
quotient  output  WIDTH  registered quotient.
remainder  output  WIDTH  registered remainder.

Behaviour:
- States: IDLE, BUSY, DONE. On resetn low, asynchronously enter IDLE:
  - counter = 0;
  - quotient = 0, remainder = 0;
  - internal dividend/divisor/partial-remainder registers = 0;
  - div_valid = 0.
- stallreq_div = div_en & ~flush & (state != DONE). This is purely combinational; flush does not depend on it, so no loop exists.
- IDLE:
  - div_en & ~flush: latch sign_q = div_signed & (x[31]^y[31]) and sign_r = div_signed & x[31]. Latch |x|, |y|, taking the absolute value only when div_signed. Clear the partial remainder and counter.
  - If y == 0: go directly to DONE with quotient = all ones, remainder = x unmodified.
  - Otherwise go to BUSY.
- BUSY: one restoring step per cycle.
  - Shift {partial_rem, dividend} left by 1.
  - Trial subtract |y| at WIDTH+1 bits.
  - If non-negative, keep the difference and set the quotient LSB to 1; else restore and set it to 0.
  - counter++ each cycle. On the step with counter == WIDTH-1 (the 32nd step), go to DONE and register:
    - quotient = sign_q ? -q : q;
    - remainder = sign_r ? -r : r (two's complement, mod 2^WIDTH).
- Latency (y != 0): stallreq_div is high for 33 cycles (1 IDLE + 32 BUSY). div_valid rises on the 34th cycle, when stallreq_div goes low. For y == 0, stallreq_div is high for 1 cycle.
- DONE:
  - div_valid = 1; quotient and remainder are held stable.
  - If ex_stall = 1: stay in DONE with no restart, even though div_en is still high.
  - If ex_stall = 0: go to IDLE. A back-to-back divide entering EX next cycle then starts normally.
  - If div_en drops without ex_stall = 0: also go to IDLE.
- flush = 1 in any state: go to IDLE on the next edge. stallreq_div is 0 that same cycle; partial results are discarded and div_valid = 0. Flush has priority over a start and over DONE hold.
- Signed overflow: -2^31 / -1 gives quotient 0x80000000, remainder 0; this falls out of the absolute-value path and needs no special case.
- Remainder sign follows the dividend. Quotient truncates toward zero.
- Result for any sign combination with y == 0: quotient 0xFFFFFFFF, remainder x.
- div_signed, x and y are ignored after start; EX may change them only after DONE.

Test Plan:
1. Unsigned 100/7, div_en held, ex_stall low after done -> stallreq_div high exactly 33 cycles, then div_valid = 1, quotient = 14, remainder = 2; IDLE one cycle later.
2. Signed 0xFFFFFFF9 (-7) / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7 / 0xFFFFFFFE (-2) -> quotient 0xFFFFFFFD, remainder 1.
3. Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0. Same operands unsigned -> quotient 0, remainder 0x80000000.
4. Divide by zero, x = 0x00001234 -> stallreq_div high 1 cycle, then quotient 0xFFFFFFFF, remainder 0x00001234.
5. flush pulsed on BUSY step 10 -> stallreq_div 0 that cycle, IDLE next cycle. Restarting 100/7 gives the full 33-cycle latency and correct results. resetn pulsed low mid-BUSY -> outputs 0 immediately, IDLE.
6. ex_stall held 3 cycles in DONE -> div_valid and results stable, no restart, stallreq_div 0. Then a back-to-back 50/5 -> quotient 10, remainder 0 after a fresh 33-cycle stall.

Source files
------------

// File: rtl/ex_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : ex_div_unit
// Purpose  : Iterative restoring divider for the EX stage. It serves
//            DIV.W/DIV.WU/MOD.W/MOD.WU and produces one quotient bit per cycle.
//            It requests an EX stall while a divide is in flight, holds its
//            results until EX advances, and aborts on a pipeline flush.
// Ports    : clk, resetn (async, active-low)
//            div_en, div_signed, x, y  - request and operands, sampled at start
//            flush, ex_stall           - pipeline controller inputs
//            stallreq_div              - combinational EX stall request
//            div_valid, quotient, remainder - registered results
// Revision : 1.0 - initial release
// ============================================================================
module ex_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             div_en,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             flush,
  input  logic             ex_stall,
  output logic             stallreq_div,
  output logic             div_valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // The last restoring step happens when the counter holds WIDTH-1.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] dvd_q;    // shifting dividend; quotient bits enter at the LSB
  logic [WIDTH-1:0] dsr_q;    // divisor magnitude
  logic [WIDTH-1:0] prem_q;   // partial remainder
  logic             qsign_q;
  logic             rsign_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;
  logic             valid_q;

  logic [WIDTH-1:0] x_abs;
  logic [WIDTH-1:0] y_abs;
  logic [WIDTH:0]   trial_d;
  logic [WIDTH:0]   diff_d;
  logic [WIDTH-1:0] prem_d;
  logic [WIDTH-1:0] dvd_d;

  // Magnitudes are taken only for signed operations. -(-2^31) wraps to
  // 0x80000000, which is the correct unsigned magnitude.
  assign x_abs = (div_signed && x[WIDTH-1]) ? -x : x;
  assign y_abs = (div_signed && y[WIDTH-1]) ? -y : y;

  // One restoring step. The partial remainder is always below the divisor,
  // so the shifted value fits in WIDTH+1 bits. The MSB of the difference is
  // the borrow.
  always_comb begin
    trial_d = {prem_q, dvd_q[WIDTH-1]};
    diff_d  = trial_d - {1'b0, dsr_q};
    if (!diff_d[WIDTH]) begin
      prem_d = diff_d[WIDTH-1:0];
      dvd_d  = {dvd_q[WIDTH-2:0], 1'b1};
    end else begin
      prem_d = trial_d[WIDTH-1:0];
      dvd_d  = {dvd_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      prem_q  <= '0;
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
    end else if (flush) begin
      // Flush wins over a start and over holding a finished result.
      state_q <= S_IDLE;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (div_en) begin
            qsign_q <= div_signed & (x[WIDTH-1] ^ y[WIDTH-1]);
            rsign_q <= div_signed & x[WIDTH-1];
            dvd_q   <= x_abs;
            dsr_q   <= y_abs;
            prem_q  <= '0;
            cnt_q   <= '0;
            if (y == '0) begin
              // Divide by zero: all-ones quotient, raw dividend as remainder.
              quot_q  <= '1;
              rem_q   <= x;
              valid_q <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          prem_q <= prem_d;
          dvd_q  <= dvd_d;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            quot_q  <= qsign_q ? -dvd_d : dvd_d;
            rem_q   <= rsign_q ? -prem_d : prem_d;
            valid_q <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          // Hold the result only while the same instruction is stalled in EX.
          if (!(ex_stall && div_en)) begin
            valid_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign stallreq_div = div_en & ~flush & (state_q != S_DONE);
  assign div_valid    = valid_q;
  assign quotient     = quot_q;
  assign remainder    = rem_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_div_unit
// Purpose  : Self-checking bench for ex_div_unit. It uses directed vectors, a
//            transaction-level reference model, and a per-cycle compare process.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_div_unit;

  logic        clk;
  logic        resetn;
  logic        div_en;
  logic        div_signed;
  logic [31:0] x;
  logic [31:0] y;
  logic        flush;
  logic        ex_stall;
  logic        stallreq_div;
  logic        div_valid;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int checks   = 0;
  int failures = 0;
  bit check_en = 1'b0;

  ex_div_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .div_en       (div_en),
    .div_signed   (div_signed),
    .x            (x),
    .y            (y),
    .flush        (flush),
    .ex_stall     (ex_stall),
    .stallreq_div (stallreq_div),
    .div_valid    (div_valid),
    .quotient     (quotient),
    .remainder    (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: truncating division; the remainder takes the
  // dividend's sign. The 64-bit path avoids the INT_MIN/-1 trap.
  function automatic void model_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
    longint sa;
    longint sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Transaction-level model: a divide occupies 32 cycles after its start
  // cycle. A divide by zero finishes at once. A result is held while EX
  // stays stalled on it.
  bit          m_busy;
  bit          m_done;
  int          m_left;
  logic [31:0] m_q;
  logic [31:0] m_r;
  logic [31:0] m_pq;
  logic [31:0] m_pr;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_left = 0;
      m_q    = 32'd0;
      m_r    = 32'd0;
    end else if (flush) begin
      m_busy = 1'b0;
      m_done = 1'b0;
    end else if (m_done) begin
      if (!(ex_stall && div_en)) m_done = 1'b0;
    end else if (m_busy) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        m_q    = m_pq;
        m_r    = m_pr;
      end
    end else if (div_en) begin
      model_div(div_signed, x, y, m_pq, m_pr);
      if (y == 32'd0) begin
        m_done = 1'b1;
        m_q    = m_pq;
        m_r    = m_pr;
      end else begin
        m_busy = 1'b1;
        m_left = 32;
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (check_en && resetn) begin
      chk("cyc_stallreq", {31'd0, stallreq_div}, {31'd0, div_en & ~flush & ~m_done});
      chk("cyc_valid", {31'd0, div_valid}, {31'd0, m_done});
      if (m_done) begin
        chk("cyc_quotient", quotient, m_q);
        chk("cyc_remainder", remainder, m_r);
      end
    end
  end

  // Stimulus is applied just after the rising edge.
  task automatic start(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    div_en     = 1'b1;
    div_signed = s;
    x          = a;
    y          = b;
    ex_stall   = 1'b1;
  endtask

  // Counts the stall cycles until div_valid is seen. Returns at the falling
  // edge of the first DONE cycle.
  task automatic wait_done(output int n);
    bit seen;
    n    = 0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (stallreq_div) n++;
      if (div_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL wait_done: div_valid never rose within 100 cycles");
    end
  endtask

  // Called from the DONE cycle. EX advances, and the next instruction is not a
  // divide.
  task automatic release_ex();
    #1 ex_stall = 1'b0;
    @(posedge clk);
    #1 div_en = 1'b0;
    @(negedge clk);
    chk("release_valid", {31'd0, div_valid}, 32'd0);
    chk("release_stall", {31'd0, stallreq_div}, 32'd0);
  endtask

  task automatic run_div(input string name, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input int exp_n,
                         input logic [31:0] eq, input logic [31:0] er);
    int n;
    start(s, a, b);
    wait_done(n);
    chk({name, "_lat"}, n, exp_n);
    chk({name, "_q"}, quotient, eq);
    chk({name, "_r"}, remainder, er);
    release_ex();
  endtask

  initial begin
    logic [31:0] tq;
    logic [31:0] tr;
    int          n;

    resetn     = 1'b0;
    div_en     = 1'b0;
    div_signed = 1'b0;
    x          = 32'd0;
    y          = 32'd0;
    flush      = 1'b0;
    ex_stall   = 1'b0;

    // Pin the reference model with hand-computed values.
    model_div(1'b1, 32'hFFFF_FFF9, 32'd2, tq, tr);
    chk("model_s_neg7_2_q", tq, 32'hFFFF_FFFD);
    chk("model_s_neg7_2_r", tr, 32'hFFFF_FFFF);
    model_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, tq, tr);
    chk("model_ovf_q", tq, 32'h8000_0000);
    chk("model_ovf_r", tr, 32'd0);
    model_div(1'b0, 32'd100, 32'd7, tq, tr);
    chk("model_u_100_7_q", tq, 32'd14);
    chk("model_u_100_7_r", tr, 32'd2);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'd0, div_valid}, 32'd0);
    chk("rst_q", quotient, 32'd0);
    chk("rst_r", remainder, 32'd0);
    resetn   = 1'b1;
    check_en = 1'b1;

    // 1: unsigned 100/7
    run_div("u100_7", 1'b0, 32'd100, 32'd7, 33, 32'd14, 32'd2);

    // 2: signed mixed signs
    run_div("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_div("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD, 32'd1);

    // 3: signed overflow, and the same operands unsigned
    run_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'd0);
    run_div("u_big", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000);

    // 4: divide by zero, signed and unsigned
    run_div("dz_u", 1'b0, 32'h0000_1234, 32'd0, 1, 32'hFFFF_FFFF, 32'h0000_1234);
    run_div("dz_s", 1'b1, 32'hFFFF_FF00, 32'd0, 1, 32'hFFFF_FFFF, 32'hFFFF_FF00);

    // 5: flush on BUSY step 10, then a clean restart
    start(1'b0, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("flush_stall", {31'd0, stallreq_div}, 32'd0);
    @(posedge clk);
    #1;
    flush  = 1'b0;
    div_en = 1'b0;
    @(negedge clk);
    chk("flush_idle_valid", {31'd0, div_valid}, 32'd0);
    run_div("after_flush", 1'b0, 32'd100, 32'd7, 33, 32'd14, 32'd2);

    // 5b: asynchronous reset in the middle of BUSY
    start(1'b0, 32'd1000, 32'd3);
    repeat (5) @(posedge clk);
    #1;
    resetn = 1'b0;
    div_en = 1'b0;
    #1;
    chk("arst_q", quotient, 32'd0);
    chk("arst_r", remainder, 32'd0);
    chk("arst_valid", {31'd0, div_valid}, 32'd0);
    chk("arst_stall", {31'd0, stallreq_div}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // 6: hold in DONE for 3 cycles, then a back-to-back 50/5
    start(1'b0, 32'd100, 32'd7);
    wait_done(n);
    chk("hold_lat", n, 33);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      chk("hold_valid", {31'd0, div_valid}, 32'd1);
      chk("hold_stall", {31'd0, stallreq_div}, 32'd0);
      chk("hold_q", quotient, 32'd14);
      chk("hold_r", remainder, 32'd2);
    end
    #1 ex_stall = 1'b0;
    start(1'b0, 32'd50, 32'd5);
    wait_done(n);
    chk("b2b_lat", n, 33);
    chk("b2b_q", quotient, 32'd10);
    chk("b2b_r", remainder, 32'd0);
    release_ex();

    repeat (3) @(negedge clk);
    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
